half_sine_player: RTL

//  Reads the shared half-sine lookup table (rising trough->peak, 8-bit unsigned)
//  and plays it back as a continuous full-period sine sample stream: index walks
//  up to table_size, reflects, walks down to 0, reflects, repeats. Programmable

---
 rtl/sine_pkg.sv | 17 +
 rtl/sine_index_reflect.sv | 66 ++++++
 rtl/half_sine_player.sv | 103 ++++++++++
 3 files changed

// File: rtl/sine_pkg.sv
// Shared constants and types for the sine playback path.
package sine_pkg;

  localparam int SINE_SIZE      = 8;
  localparam int TABLE_SIZE     = 56;
  localparam int TABLE_REG_SIZE = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PRESENT = 2'd2
  } player_state_t;

  typedef logic [SINE_SIZE-1:0]      sample_t;
  typedef logic [TABLE_REG_SIZE-1:0] index_t;

endpackage

// File: rtl/sine_index_reflect.sv
// Next table index for the reflecting walk: the index bounces between 0 and
// table_size so the half-sine table plays back as a full period.
module sine_index_reflect
  import sine_pkg::*;
#(
  parameter int STRIDE_W = 4
) (
  input  logic [TABLE_REG_SIZE-1:0] index,
  input  logic                      dir_down,
  input  logic [STRIDE_W-1:0]       stride,
  input  logic [TABLE_REG_SIZE-1:0] table_size,
  output logic [TABLE_REG_SIZE-1:0] next_index,
  output logic                      next_dir_down,
  output logic                      wrap
);

  // Two extra bits so index+stride and 2*table_size never overflow before compare.
  localparam int AW = TABLE_REG_SIZE + 2;

  logic [AW-1:0] idx_w;
  logic [AW-1:0] ts_w;
  logic [AW-1:0] ts2_w;
  logic [AW-1:0] s_w;
  logic [AW-1:0] sum_w;
  logic [AW-1:0] refl_top_w;
  logic [AW-1:0] dec_w;
  logic [AW-1:0] refl_bot_w;

  // Reflect at the peak (going up) or at the trough (going down).
  always_comb begin
    idx_w         = AW'(index);
    ts_w          = AW'(table_size);
    ts2_w         = ts_w << 1;
    s_w           = (stride == '0) ? AW'(1) : AW'(stride);
    sum_w         = idx_w + s_w;
    refl_top_w    = ts2_w - sum_w;
    dec_w         = idx_w - s_w;
    refl_bot_w    = s_w - idx_w;
    next_index    = index;
    next_dir_down = dir_down;
    wrap          = 1'b0;

    if (idx_w > ts_w) begin
      // table_size shrank below the current index: park at the new peak.
      next_index    = table_size;
      next_dir_down = 1'b1;
    end else if (!dir_down) begin
      if (sum_w <= ts_w) begin
        next_index = sum_w[TABLE_REG_SIZE-1:0];
      end else begin
        next_dir_down = 1'b1;
        // A stride larger than table_size would fold below zero; pin to trough.
        next_index    = (sum_w > ts2_w) ? '0 : refl_top_w[TABLE_REG_SIZE-1:0];
      end
    end else begin
      if (idx_w >= s_w) begin
        next_index = dec_w[TABLE_REG_SIZE-1:0];
      end else begin
        next_dir_down = 1'b0;
        wrap          = 1'b1;
        next_index    = (refl_bot_w > ts_w) ? table_size : refl_bot_w[TABLE_REG_SIZE-1:0];
      end
    end
  end

endmodule

// File: rtl/half_sine_player.sv
// Plays the half-sine table back as a continuous sine sample stream with a
// valid/ready output. One sample per CLK_DIV run cycles plus the handshake.
//
// state   | meaning
// IDLE    | playback stopped, index/dir held for resume
// RUN     | divider counting toward the next sample load
// PRESENT | sample valid, waiting for sample_ready
module half_sine_player
  import sine_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int STRIDE_W = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [TABLE_SIZE-1:0][SINE_SIZE-1:0]  sine_wave,
  input  logic [TABLE_REG_SIZE-1:0]             table_size,
  input  logic                                  enable,
  input  logic [STRIDE_W-1:0]                   stride,
  input  logic                                  sample_ready,
  output logic                                  sample_valid,
  output sample_t                               sample,
  output logic [TABLE_REG_SIZE-1:0]             index,
  output logic                                  dir_down,
  output logic                                  cycle_done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  player_state_t             state;
  logic [DIV_W-1:0]          divider;
  sample_t                   table_word;
  logic [TABLE_REG_SIZE-1:0] nxt_index;
  logic                      nxt_dir_down;
  logic                      nxt_wrap;

  sine_index_reflect #(
    .STRIDE_W(STRIDE_W)
  ) u_reflect (
    .index        (index),
    .dir_down     (dir_down),
    .stride       (stride),
    .table_size   (table_size),
    .next_index   (nxt_index),
    .next_dir_down(nxt_dir_down),
    .wrap         (nxt_wrap)
  );

  // Table lookup as a compare mux so an index beyond the table reads zero.
  always_comb begin
    table_word = '0;
    for (int i = 0; i < TABLE_SIZE; i++) begin
      if (index == TABLE_REG_SIZE'(i)) table_word = sine_wave[i];
    end
  end

  // Playback FSM with divider and registered stream outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      divider      <= '0;
      index        <= '0;
      dir_down     <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      cycle_done   <= 1'b0;
    end else begin
      cycle_done <= 1'b0;
      case (state)
        IDLE: begin
          divider <= '0;
          if (enable) state <= RUN;
        end
        RUN: begin
          if (!enable) begin
            divider <= '0;
            state   <= IDLE;
          end else if (divider == DIV_LAST) begin
            sample       <= table_word;
            sample_valid <= 1'b1;
            divider      <= '0;
            state        <= PRESENT;
          end else begin
            divider <= divider + 1'b1;
          end
        end
        PRESENT: begin
          // Stride and table_size are taken at the handshake itself.
          if (sample_ready) begin
            sample_valid <= 1'b0;
            index        <= nxt_index;
            dir_down     <= nxt_dir_down;
            cycle_done   <= nxt_wrap;
            state        <= enable ? RUN : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
